// File: rtl/bram_word_engine_pkg.sv
// Shared encodings and helpers for the BRAM word transfer engine.
package bram_word_engine_pkg;

  localparam logic [1:0] OP_PASS  = 2'd0;
  localparam logic [1:0] OP_BSWAP = 2'd1;
  localparam logic [1:0] OP_INV   = 2'd2;
  localparam logic [1:0] OP_ADDK  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Widest word the byte-reverse helper handles; callers truncate to their width.
  localparam int MAX_W = 256;

  function automatic logic [MAX_W-1:0] byte_rev(input logic [MAX_W-1:0] d, input int nbytes);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W/8; i++)
      if (i < nbytes) r[8*i +: 8] = d[8*(nbytes-1-i) +: 8];
    return r;
  endfunction

endpackage

// File: rtl/bram_word_engine_xform.sv
// Combinational per-word transform: pass, byte-reverse, invert, add key.
module word_xform
  import bram_word_engine_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        op_sel,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = data;
    case (op_sel)
      OP_BSWAP: result = DATA_W'(byte_rev(MAX_W'(data), DATA_W/8));
      OP_INV:   result = ~data;
      OP_ADDK:  result = data + key;
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/bram_word_engine.sv
// Inbound-to-outbound BRAM transfer engine with per-word transform.
// BRAM_WORD_ENGINE_CHECKSUM_EN appends a running-sum word at address len.
module bram_word_engine
  import bram_word_engine_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                start,
  input  logic [ADDR_W:0]     len,
  input  logic [1:0]          op_sel,
  input  logic [DATA_W-1:0]   key,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                wr_en,
  output logic [DATA_W/8-1:0] wr_we,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                busy,
  output logic                done
);

  localparam int STAGES = RD_LAT - 1;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef BRAM_WORD_ENGINE_CHECKSUM_EN
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH - 1);
`else
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
`endif

  state_t state, state_nxt;
  logic [ADDR_W:0]   len_q, len_clamp, len_m1;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] key_q, xf;
  logic [ADDR_W-1:0] cnt;
  logic              accept, last_rd, last_wr, fin_cond;
  logic [STAGES:0]               vld_pipe;
  logic [STAGES:0][ADDR_W-1:0]   idx_pipe;

  assign accept    = (state == ST_IDLE) && start;
  assign len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
  assign len_m1    = len_q - (ADDR_W+1)'(1);
  assign last_rd   = ({1'b0, cnt} == len_m1);
  assign last_wr   = wr_en && ({1'b0, wr_addr} == len_m1);

`ifdef BRAM_WORD_ENGINE_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              csum_wr, csum_go;
  assign csum_wr  = wr_en && ({1'b0, wr_addr} == len_q);
  // Fire once: after the last data write, or straight away for an empty transfer.
  assign csum_go  = (state == ST_DRAIN) && !csum_wr && ((len_q == '0) || last_wr);
  assign fin_cond = csum_wr;
`else
  assign fin_cond = last_wr;
`endif

  always_ff @(posedge clk) begin
    if (!rstb) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) begin
`ifdef BRAM_WORD_ENGINE_CHECKSUM_EN
        state_nxt = (len_clamp == '0) ? ST_DRAIN : ST_ISSUE;
`else
        state_nxt = (len_clamp == '0) ? ST_FIN : ST_ISSUE;
`endif
      end
      ST_ISSUE: if (last_rd)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (fin_cond) state_nxt = ST_FIN;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state == ST_ISSUE);
    busy  = (state == ST_ISSUE) || (state == ST_DRAIN);
    done  = (state == ST_FIN);
  end

  assign rd_addr = cnt;
  assign wr_we   = {(DATA_W/8){wr_en}};

  always_ff @(posedge clk) begin
    if (!rstb) begin
      len_q <= '0;
      op_q  <= '0;
      key_q <= '0;
      cnt   <= '0;
    end else if (accept) begin
      len_q <= len_clamp;
      op_q  <= op_sel;
      key_q <= key;
      cnt   <= '0;
    end else if (state == ST_ISSUE) begin
      cnt <= last_rd ? '0 : cnt + ADDR_W'(1);
    end
  end

  // Marks the cycle each issued read's data is present on rd_data.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      idx_pipe[0] <= cnt;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  word_xform #(.DATA_W(DATA_W)) u_xform (
    .op_sel (op_q),
    .key    (key_q),
    .data   (rd_data),
    .result (xf)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
`ifdef BRAM_WORD_ENGINE_CHECKSUM_EN
      sum     <= '0;
`endif
    end else begin
      wr_en <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        wr_addr <= idx_pipe[STAGES];
        wr_data <= xf;
      end
`ifdef BRAM_WORD_ENGINE_CHECKSUM_EN
      if (accept)                sum <= '0;
      else if (vld_pipe[STAGES]) sum <= sum + xf;
      if (csum_go) begin
        wr_en   <= 1'b1;
        wr_addr <= len_q[ADDR_W-1:0];
        wr_data <= sum;
      end
`endif
    end
  end

endmodule

// File: doc/bram_word_engine.md
Name: bram_word_engine

Overview:
- Application-clock stage between the inbound 32-bit BRAM (filled via SPI) and the outbound 32-bit BRAM (drained via SPI).
- On `start`, reads `len` consecutive words from inbound address 0 upward and applies a selectable 32-bit transform to each word.
- Writes each result to the same index in the outbound BRAM, then pulses `done`.
- Replaces the free-running user application with a controlled, countable transfer engine.

Parameters:
- ADDR_W, 10, word address width of both BRAMs (DEPTH = 2**ADDR_W).
- DATA_W, 32, word width; must be a multiple of 8.
- RD_LAT, 2, inbound BRAM read latency in cycles (2 = DO_REG with REGCE); legal range 1..3.

Ports:
- clk  in  1  application clock; all logic on the rising edge.
- rstb  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- len  in  ADDR_W+1  number of words to process; sampled with start.
- op_sel  in  2  transform: 0 pass, 1 byte-reverse, 2 bitwise invert, 3 add key (mod 2^DATA_W); sampled with start.
- key  in  DATA_W  operand for op 3; sampled with start.
- rd_en  out  1  inbound BRAM RDEN.
- rd_addr  out  ADDR_W  inbound BRAM RDADDR.
- rd_data  in  DATA_W  inbound BRAM DO.
- wr_en  out  1  outbound BRAM WREN.
- wr_we  out  DATA_W/8  byte enables; all ones when wr_en=1, else 0.
- wr_addr  out  ADDR_W  outbound BRAM WRADDR.
- wr_data  out  DATA_W  transformed word.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rstb=0 at an edge): state=IDLE. rd_en, wr_en, wr_we, busy and done are 0. rd_addr, wr_addr, wr_data and the counters are 0. Reset mid-transfer aborts immediately; no further BRAM accesses occur.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - start=1 and len>0: latch len/op_sel/key, go to ISSUE.
  - start=1 and len=0: go to FIN (done pulse, no BRAM access).
  - start=0: stay in IDLE.
- len > DEPTH is clamped to DEPTH.
- ISSUE: rd_en=1, rd_addr = issue count k (0..len-1), one read per cycle. After the read at k = len-1, go to DRAIN.
- Valid tracking: an RD_LAT-deep valid/index shift register marks the cycle each read's data appears on rd_data.
- Write path: transform is combinational on rd_data, then registered. A read issued at cycle c produces wr_en=1, wr_addr=k, wr_data=f(word) at cycle c+RD_LAT+1.
- DRAIN: wait until the last write has been issued, then go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- Timing (start sampled at edge t): reads at t+1..t+len; writes at t+2+RD_LAT .. t+1+RD_LAT+len; done at t+2+RD_LAT+len.
- start while busy is ignored with no effect. start in the same cycle as done (FIN) is ignored; it is accepted only in IDLE.
- Address counters are ADDR_W bits. At len = DEPTH the last address is DEPTH-1 and the counter never wraps into reuse.
- Byte-reverse: out[8i+7:8i] = in[DATA_W-1-8i : DATA_W-8-8i].

Optional Feature:
- Macro: BRAM_WORD_ENGINE_CHECKSUM_EN.
- Defined:
  - An internal DATA_W accumulator sums every written wr_data (mod 2^DATA_W).
  - After the last data write, one extra write at wr_addr = len carries the sum; done follows one cycle later.
  - len is clamped to DEPTH-1 instead of DEPTH.
  - len=0 writes checksum 0 at address 0.
- Undefined: no accumulator, no extra write, timing as above.

Decomposition:
- Package bram_word_engine_pkg:
  - op_sel encodings OP_PASS, OP_BSWAP, OP_INV, OP_ADDK.
  - State encoding constants.
  - Byte-reverse function.
- Sub-module word_xform: purely combinational, inputs op_sel/key/data, output transformed word. Reused by verification as the reference model.

Test Plan:
- rstb=0 mid-ISSUE with len=8 -> next cycle all outputs 0, no further rd_en/wr_en; a new start is then accepted.
- Inbound words 0x00000000..0x00000003, len=4, op=0, RD_LAT=2 -> writes at addr 0..3 with identical data; done at t+8; busy high t+1..t+7.
- Word 0x11223344, len=1, op=1 -> wr_data=0x44332211 at addr 0; op=2 -> 0xEEDDCCBB; op=3 with key=0xFFFFFFFF -> 0x11223343 (wraps).
- len=0 -> done at t+1, rd_en/wr_en never asserted. len=1500 -> exactly 1024 writes; last wr_addr=1023.
- start pulsed again during busy with a different len/op -> ignored; output matches the first request only.
- CHECKSUM_EN, len=2, op=0, words 0xFFFFFFFF and 0x00000002 -> extra write at addr 2 with data 0x00000001; done one cycle after it.
